// File: rtl/clause_eval_scheduler.sv
// clause_eval_scheduler: sweeps the clause RAM one clause per cycle during a
// BCP pass and folds the evaluator verdicts into a single pass result.
// Optional build macro: SCHED_EARLY_EXIT_EN (end the pass on the first unit or
// conflict verdict instead of scanning every active clause).
//
// state | meaning
// IDLE  | waiting for start; result/result_idx hold the last pass outcome
// ISSUE | one clause read per cycle, rd_ptr = 0 .. limit-1
// DRAIN | last read issued, waiting for its verdict
// DONE  | done pulse; result registers already hold the new outcome
module clause_eval_scheduler #(
    parameter int NUM_CLAUSES = 1023,
    parameter int IDX_W       = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W-1:0] clause_count,
    output logic             mem_rd_en,
    output logic [IDX_W-1:0] mem_rd_addr,
    input  logic             ev_sat,
    input  logic             ev_unit,
    input  logic             ev_conflict,
    output logic             busy,
    output logic             done,
    output logic [1:0]       result,
    output logic [IDX_W-1:0] result_idx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] RES_ALL_SAT  = 2'b00;
    localparam logic [1:0] RES_UNIT     = 2'b01;
    localparam logic [1:0] RES_CONFLICT = 2'b10;
    localparam logic [1:0] RES_UNDET    = 2'b11;

    localparam logic [IDX_W-1:0] MAX_COUNT = IDX_W'(NUM_CLAUSES);
    localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0] limit_q, limit_d;
    logic             eval_valid_q, eval_valid_d;
    logic [IDX_W-1:0] eval_idx_q, eval_idx_d;
    logic             all_sat_q, all_sat_d;
    logic             unit_found_q, unit_found_d;
    logic [IDX_W-1:0] unit_idx_q, unit_idx_d;
    logic             conf_found_q, conf_found_d;
    logic [IDX_W-1:0] conf_idx_q, conf_idx_d;
    logic [1:0]       result_q, result_d;
    logic [IDX_W-1:0] result_idx_q, result_idx_d;

    logic [1:0]       fin_res;
    logic [IDX_W-1:0] fin_idx;
`ifdef SCHED_EARLY_EXIT_EN
    logic             deciding;
`endif

    // Next-state, scan flag accumulation and result selection.
    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        limit_d      = limit_q;
        eval_valid_d = 1'b0;
        eval_idx_d   = rd_ptr_q;
        all_sat_d    = all_sat_q;
        unit_found_d = unit_found_q;
        unit_idx_d   = unit_idx_q;
        conf_found_d = conf_found_q;
        conf_idx_d   = conf_idx_q;
        result_d     = result_q;
        result_idx_d = result_idx_q;

        // Fold in the verdict for the clause read last cycle. A clause that
        // is both unit and conflicting counts only as a conflict.
        if (eval_valid_q) begin
            if (!ev_sat) begin
                all_sat_d = 1'b0;
            end
            if (ev_conflict && !conf_found_q) begin
                conf_found_d = 1'b1;
                conf_idx_d   = eval_idx_q;
            end
            if (ev_unit && !ev_conflict && !unit_found_q) begin
                unit_found_d = 1'b1;
                unit_idx_d   = eval_idx_q;
            end
        end

        // Outcome including this cycle's verdict, used when entering DONE.
        if (conf_found_d) begin
            fin_res = RES_CONFLICT;
            fin_idx = conf_idx_d;
        end else if (unit_found_d) begin
            fin_res = RES_UNIT;
            fin_idx = unit_idx_d;
        end else if (all_sat_d) begin
            fin_res = RES_ALL_SAT;
            fin_idx = '0;
        end else begin
            fin_res = RES_UNDET;
            fin_idx = '0;
        end

`ifdef SCHED_EARLY_EXIT_EN
        deciding = eval_valid_q && (ev_conflict || ev_unit);
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    limit_d      = (clause_count > MAX_COUNT) ? MAX_COUNT : clause_count;
                    rd_ptr_d     = '0;
                    all_sat_d    = 1'b1;
                    unit_found_d = 1'b0;
                    unit_idx_d   = '0;
                    conf_found_d = 1'b0;
                    conf_idx_d   = '0;
                    if (clause_count == '0) begin
                        state_d      = S_DONE;
                        result_d     = RES_ALL_SAT;
                        result_idx_d = '0;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    eval_valid_d = 1'b1;
                    if (rd_ptr_q == limit_q - ONE) begin
                        state_d = S_DRAIN;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ONE;
                    end
`ifdef SCHED_EARLY_EXIT_EN
                    // The read issued this cycle is dropped along with its verdict.
                    if (deciding) begin
                        state_d      = S_DONE;
                        eval_valid_d = 1'b0;
                        result_d     = fin_res;
                        result_idx_d = fin_idx;
                    end
`endif
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d      = S_DONE;
                    result_d     = fin_res;
                    result_idx_d = fin_idx;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rd_ptr_q     <= '0;
            limit_q      <= '0;
            eval_valid_q <= 1'b0;
            eval_idx_q   <= '0;
            all_sat_q    <= 1'b1;
            unit_found_q <= 1'b0;
            unit_idx_q   <= '0;
            conf_found_q <= 1'b0;
            conf_idx_q   <= '0;
            result_q     <= RES_UNDET;
            result_idx_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            limit_q      <= limit_d;
            eval_valid_q <= eval_valid_d;
            eval_idx_q   <= eval_idx_d;
            all_sat_q    <= all_sat_d;
            unit_found_q <= unit_found_d;
            unit_idx_q   <= unit_idx_d;
            conf_found_q <= conf_found_d;
            conf_idx_q   <= conf_idx_d;
            result_q     <= result_d;
            result_idx_q <= result_idx_d;
        end
    end

    // Outputs decode directly from registered state.
    always_comb begin
        mem_rd_en   = (state_q == S_ISSUE);
        mem_rd_addr = (state_q == S_ISSUE) ? rd_ptr_q : '0;
        busy        = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        done        = (state_q == S_DONE);
        result      = result_q;
        result_idx  = result_idx_q;
    end

endmodule

// File: tb/tb_clause_eval_scheduler.sv
// Bench for clause_eval_scheduler: random verdict patterns, a reference model
// of the pass outcome, and a done-driven scoreboard monitor.
// Honors SCHED_EARLY_EXIT_EN to select the matching reference behaviour.
module tb_clause_eval_scheduler;

    localparam int IDX_W       = 10;
    localparam int NUM_CLAUSES = 1023;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [IDX_W-1:0] clause_count = '0;
    logic             mem_rd_en;
    logic [IDX_W-1:0] mem_rd_addr;
    logic             ev_sat = 1'b0;
    logic             ev_unit = 1'b0;
    logic             ev_conflict = 1'b0;
    logic             busy;
    logic             done;
    logic [1:0]       result;
    logic [IDX_W-1:0] result_idx;

    clause_eval_scheduler #(.NUM_CLAUSES(NUM_CLAUSES), .IDX_W(IDX_W)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .clause_count(clause_count), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .ev_sat(ev_sat), .ev_unit(ev_unit), .ev_conflict(ev_conflict),
        .busy(busy), .done(done), .result(result), .result_idx(result_idx)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        int res;
        int idx;
        int cyc;
        int reads;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_res  = 3;
    int   exp_idx  = 0;

    bit v_sat  [NUM_CLAUSES];
    bit v_unit [NUM_CLAUSES];
    bit v_conf [NUM_CLAUSES];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference outcome of a pass over clauses 0..n-1 started in cycle s.
    function automatic exp_t model(input int n, input int s);
        exp_t e;
        int   first_c   = -1;
        int   first_u   = -1;
        int   first_any = -1;
        bit   all       = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (!v_sat[k]) all = 1'b0;
            if (v_conf[k] && first_c < 0) first_c = k;
            if (v_unit[k] && !v_conf[k] && first_u < 0) first_u = k;
            if ((v_conf[k] || v_unit[k]) && first_any < 0) first_any = k;
        end
        e.reads = n;
        e.cyc   = s + ((n == 0) ? 1 : n + 2);
`ifdef SCHED_EARLY_EXIT_EN
        if (first_any >= 0) begin
            e.res   = v_conf[first_any] ? 2 : 1;
            e.idx   = first_any;
            e.cyc   = s + first_any + 3;
            e.reads = (first_any + 2 < n) ? first_any + 2 : n;
            return e;
        end
`endif
        if (first_c >= 0) begin
            e.res = 2; e.idx = first_c;
        end else if (first_u >= 0) begin
            e.res = 1; e.idx = first_u;
        end else if (all) begin
            e.res = 0; e.idx = 0;
        end else begin
            e.res = 3; e.idx = 0;
        end
        return e;
    endfunction

    // Clause RAM + evaluator: verdict for the address read in the previous
    // cycle; random junk when nothing was read.
    logic             cap_en;
    logic [IDX_W-1:0] cap_addr;
    always begin
        @(negedge clock);
        cap_en   = mem_rd_en;
        cap_addr = mem_rd_addr;
        @(posedge clock);
        #1;
        if (cap_en) begin
            ev_sat      = v_sat[int'(cap_addr)];
            ev_unit     = v_unit[int'(cap_addr)];
            ev_conflict = v_conf[int'(cap_addr)];
        end else begin
            ev_sat      = 1'($urandom);
            ev_unit     = 1'($urandom);
            ev_conflict = 1'($urandom);
        end
    end

    // Scoreboard monitor.
    int   read_cnt = 0;
    exp_t mon_e;
    always @(negedge clock) begin
        if (mem_rd_en) begin
            check("rd_addr", int'(mem_rd_addr), read_cnt);
            read_cnt++;
        end
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("result", int'(result), mon_e.res);
                check("result_idx", int'(result_idx), mon_e.idx);
                check("done_cycle", cyc, mon_e.cyc);
                check("read_count", read_cnt, mon_e.reads);
            end
        end
        if (!busy) read_cnt = 0;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_all();
        for (int k = 0; k < NUM_CLAUSES; k++) begin
            v_sat[k] = 1'b1; v_unit[k] = 1'b0; v_conf[k] = 1'b0;
        end
    endtask

    task automatic fill_random(input int n, input int dens);
        int r;
        for (int k = 0; k < n; k++) begin
            r = int'($urandom_range(0, 999));
            v_conf[k] = (r < dens);
            v_unit[k] = (r < dens) ? 1'($urandom) : (r < 2 * dens);
            v_sat[k]  = !v_conf[k] && !v_unit[k] && ($urandom_range(0, 9) != 0);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rd_en"}, int'(mem_rd_en), 0);
        check({tag, "_rd_addr"}, int'(mem_rd_addr), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_result"}, int'(result), 3);
        check({tag, "_result_idx"}, int'(result_idx), 0);
    endtask

    // One full pass; optionally raise start in the done cycle, which must be ignored.
    task automatic run_pass(input int n, input bit b2b);
        exp_t e;
        bit   got;
        check("result_held", int'(result), exp_res);
        check("result_idx_held", int'(result_idx), exp_idx);
        e = model(n, cyc);
        sb.push_back(e);
        exp_res = e.res;
        exp_idx = e.idx;
        start = 1'b1;
        clause_count = IDX_W'(n);
        tick();
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < n + 12; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("done_seen", int'(got), 1);
        if (b2b) begin
            start = 1'b1;
            clause_count = IDX_W'(5);
            tick();
            start = 1'b0;
            tick();
            check("ignored_start_busy", int'(busy), 0);
            check("ignored_start_rd_en", int'(mem_rd_en), 0);
        end else begin
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

    initial begin
        int dens_tab[4];
        int n;
        dens_tab[0] = 0; dens_tab[1] = 5; dens_tab[2] = 30; dens_tab[3] = 150;
        clear_all();
        repeat (3) tick();
        check_reset_vals("por");
        reset = 1'b0;
        tick();

        clear_all();
        run_pass(0, 1'b0);
        run_pass(4, 1'b0);

        clear_all();
        v_unit[2] = 1'b1; v_sat[2] = 1'b0;
        v_conf[5] = 1'b1; v_sat[5] = 1'b0;
        run_pass(8, 1'b1);

        clear_all();
        v_unit[0] = 1'b1; v_conf[0] = 1'b1; v_sat[0] = 1'b0;
        run_pass(1, 1'b0);

        for (int p = 0; p < 40; p++) begin
            n = (p % 7 == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(1, 40));
            fill_random(n, dens_tab[p % 4]);
            run_pass(n, (p % 5) == 0);
        end

        // Abort a long pass in cycle 500.
        clear_all();
        start = 1'b1;
        clause_count = IDX_W'(1023);
        tick();
        start = 1'b0;
        repeat (499) tick();
        check("abort_busy_before", int'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_rd_en", int'(mem_rd_en), 0);
        check("abort_result", int'(result), exp_res);
        check("abort_result_idx", int'(result_idx), exp_idx);
        repeat (4) tick();
        check("abort_idle_rd_en", int'(mem_rd_en), 0);
        fill_random(12, 30);
        run_pass(12, 1'b0);

        // Reset in cycle 3 of a pass, with start raised alongside it.
        fill_random(6, 30);
        start = 1'b1;
        clause_count = IDX_W'(6);
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check_reset_vals("midreset");
        tick();
        check("midreset_start_ignored", int'(busy), 0);
        exp_res = 3;
        exp_idx = 0;
        fill_random(10, 30);
        run_pass(10, 1'b0);

        repeat (5) tick();
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clause_eval_scheduler.md
# clause_eval_scheduler

Sequencer that sweeps the clause memory one clause per cycle and drives the clause evaluators (partial-SAT and unit-clause logic) during each BCP pass of the SAT solver. It issues clause read addresses and collects the per-clause evaluator verdicts one cycle later. It reports one pass result (all satisfied, unit found, conflict, or undetermined) together with the index of the deciding clause. It sits between the solver's top-level decision/propagation FSM and the clause RAM plus evaluator datapath.

## Interface
- NUM_CLAUSES, 1023, maximum clauses held in clause memory
- IDX_W, 10, clause index width; must satisfy 2^IDX_W > NUM_CLAUSES
- clock  input  1  single clock; all logic is rising-edge
- reset  input  1  synchronous, active-high; takes effect on the rising edge where it is sampled high
- start  input  1  one-cycle request to begin a pass; honoured only in IDLE
- abort  input  1  cancels a pass in progress; no done is produced
- clause_count  input  IDX_W  number of active clauses, 0..NUM_CLAUSES; sampled on the accepted start
- mem_rd_en  output  1  clause RAM read strobe; the RAM has a fixed 1-cycle read latency
- mem_rd_addr  output  IDX_W  clause index being read
- ev_sat  input  1  evaluator verdict for the clause read on the previous cycle: satisfied
- ev_unit  input  1  same clause: exactly one literal is unassigned and the clause is otherwise false
- ev_conflict  input  1  same clause: all literals are assigned false
- busy  output  1  high from the cycle after an accepted start until done or abort
- done  output  1  one-cycle pulse marking the end of a pass
- result  output  2  00 ALL_SAT, 01 UNIT, 10 CONFLICT, 11 UNDETERMINED; held until the next accepted start
- result_idx  output  IDX_W  index of the deciding clause for UNIT or CONFLICT; 0 otherwise

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start loads the limit register and clears the scan flags.
  - If clause_count is 0, go to DONE with result ALL_SAT.
  - Otherwise go to ISSUE.
- ISSUE:
  - Assert mem_rd_en with mem_rd_addr = rd_ptr; rd_ptr runs 0..clause_count-1.
  - After issuing the last index, go to DRAIN.
- Verdict pipeline:
  - An eval_valid flag follows each issued read by exactly one cycle, with eval_idx = the issued address.
  - ev_* are sampled only when eval_valid is high.
- DRAIN: wait one cycle for the last verdict, then go to DONE.
- DONE: pulse done for one cycle, latch result and result_idx, then go to IDLE.
- Flags:
  - all_sat_flag clears on any valid verdict with ev_sat=0.
  - The first valid ev_unit records unit_idx.
  - The first valid ev_conflict records conflict_idx.
  - If ev_conflict and ev_unit are both high for the same clause, it is treated as a conflict.
- Final result priority: CONFLICT > UNIT > ALL_SAT (all_sat_flag still set) > UNDETERMINED.
- start outside IDLE is ignored.
- abort in ISSUE or DRAIN:
  - Go to IDLE on the next edge and deassert busy.
  - result and result_idx keep their previous values.
- Reset mid-pass:
  - All state returns to IDLE and all outputs take their reset values.
  - Any in-flight verdict is discarded.

## Timing
- Reset values: mem_rd_en=0, mem_rd_addr=0, busy=0, done=0, result=11, result_idx=0.
- start is accepted in cycle 0. The first read issues in cycle 1 with addr 0.
- The verdict for clause k is sampled in cycle k+2.
- Full pass of N clauses (N ≥ 1):
  - Reads issue in cycles 1..N.
  - done and the new result are visible in cycle N+2; busy drops in the same cycle.
- clause_count=0: done in cycle 1, no reads issued.
- Back-to-back passes: start may be asserted in the cycle done is high. The FSM is then back in IDLE on the next edge, so that start is not accepted; the next start must come one cycle after done.
- Early exit (see Configuration):
  - A deciding verdict sampled in cycle k+2 gives done in cycle k+3.
  - The read already issued for clause k+1 is dropped, and its verdict is ignored.

## Configuration
- SCHED_EARLY_EXIT_EN defined:
  - The first valid ev_conflict or ev_unit ends the pass.
  - ISSUE stops immediately and the FSM goes straight to DONE.
  - The result is whichever kind occurred first in index order; within one clause, conflict wins.
- Undefined: every pass scans all clause_count clauses and applies the priority rule above.

## Test plan
- clause_count=0, start → no mem_rd_en, done in cycle 1, result=00.
- clause_count=4, ev_sat=1 for all → addrs 0,1,2,3 issued in cycles 1-4, done in cycle 6, result=00, result_idx=0.
- clause_count=8, ev_unit on clause 2, ev_conflict on clause 5, macro undefined → done in cycle 10, result=10, result_idx=5.
- Same stimulus with SCHED_EARLY_EXIT_EN → done in cycle 5, result=01, result_idx=2, addr 3 is the last read issued.
- clause_count=1023, abort in cycle 500 → busy=0 and mem_rd_en=0 from cycle 501, no done, result unchanged; a new start then completes a normal pass.
- clause_count=6, reset in cycle 3 → all outputs at reset values next cycle; a start raised during reset is ignored.
